// File: rtl/rotation_sync.sv
// rotation_sync: hall-pulse revolution timing for the POV display.
// Optional macro SLICE_OFFSET_EN adds phase_offset.
//
// Ports:
//   clock, reset  - clock, async active-high reset
//   hall_in       - raw hall sensor pulse, asynchronous
//   phase_offset  - slice rotation (only with SLICE_OFFSET_EN)
//   cycle_marker  - display-enable window for current slice
//   slice_idx     - current angular slice
//   locked        - high while in RUN
//   period        - last accepted revolution period (clocks)
//   timeout       - one-cycle pulse on period counter saturation
module rotation_sync #(
  parameter int SLICES     = 64,
  parameter int CNT_W      = 24,
  parameter int DEBOUNCE   = 4,
  parameter int MIN_PERIOD = 1024,
  parameter int DUTY_SHIFT = 1,
  localparam int SW = $clog2(SLICES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hall_in,
`ifdef SLICE_OFFSET_EN
  input  logic [SW-1:0]    phase_offset,
`endif
  output logic             cycle_marker,
  output logic [SW-1:0]    slice_idx,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic             s1, s2;
  logic [DW-1:0]    dcnt;
  logic             armed;
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [CNT_W-1:0] scnt, scnt_n;
  logic [CNT_W-1:0] slen, slen_n;
  logic [CNT_W-1:0] per_n;
  logic [SW-1:0]    sidx, sidx_n;
  logic             hold, hold_n;
  logic             to_n;
  logic             cm_n;

  logic             idx;
  logic             pmax;
  logic [CNT_W:0]   mp_w;
  logic [CNT_W-1:0] mp;
  logic [CNT_W-1:0] sl_new;
  logic             long_rev;
  logic             acc;
  logic [SW-1:0]    off;

`ifdef SLICE_OFFSET_EN
  assign off = phase_offset;
`else
  assign off = '0;
`endif

  // dcnt counts earlier consecutive highs, so the
  // DEBOUNCE-th high sample sees dcnt == DEBOUNCE-1.
  assign idx  = s2 && armed && (dcnt == DW'(DEBOUNCE - 1));
  assign pmax = (pcnt == '1);

  // Measured period saturates if the counter is pinned.
  assign mp_w     = {1'b0, pcnt} + 1'b1;
  assign mp       = mp_w[CNT_W] ? '1 : mp_w[CNT_W-1:0];
  assign sl_new   = mp >> SW;
  assign long_rev = (mp >= CNT_W'(MIN_PERIOD));
  assign acc      = long_rev && (sl_new >= CNT_W'(2));

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    scnt_n  = scnt;
    slen_n  = slen;
    per_n   = period;
    sidx_n  = sidx;
    hold_n  = hold;
    to_n    = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        pcnt_n = '0;
        if (idx) state_n = MEASURE;
      end
      (state == MEASURE): begin
        pcnt_n = pmax ? pcnt : pcnt + 1'b1;
        if (idx && long_rev) begin
          per_n  = mp;
          pcnt_n = '0;
          if (acc) begin
            slen_n  = sl_new;
            scnt_n  = '0;
            sidx_n  = '0;
            hold_n  = 1'b0;
            state_n = RUN;
          end
        end else if (pmax) begin
          to_n    = 1'b1;
          pcnt_n  = '0;
          state_n = IDLE;
        end
      end
      (state == RUN): begin
        pcnt_n = pmax ? pcnt : pcnt + 1'b1;
        if (scnt == slen - CNT_W'(1)) begin
          scnt_n = '0;
          // Past the last slice: rotor slowed, hold.
          if (sidx == SW'(SLICES - 1)) hold_n = 1'b1;
          else sidx_n = sidx + 1'b1;
        end else begin
          scnt_n = scnt + 1'b1;
        end
        if (idx && long_rev) begin
          per_n  = mp;
          pcnt_n = '0;
          scnt_n = '0;
          sidx_n = '0;
          hold_n = 1'b0;
          if (acc) slen_n = sl_new;
          else state_n = MEASURE;
        end else if (pmax) begin
          to_n    = 1'b1;
          pcnt_n  = '0;
          scnt_n  = '0;
          sidx_n  = '0;
          hold_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        pcnt_n  = '0;
        scnt_n  = '0;
        sidx_n  = '0;
        hold_n  = 1'b0;
      end
    endcase
    cm_n = (state_n == RUN) && !hold_n &&
           (scnt_n < slen_n - (slen_n >> DUTY_SHIFT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      dcnt  <= '0;
      armed <= 1'b0;
    end else begin
      s1 <= hall_in;
      s2 <= s1;
      if (!s2) dcnt <= '0;
      else if (dcnt != DW'(DEBOUNCE - 1)) dcnt <= dcnt + 1'b1;
      if (idx) armed <= 1'b0;
      else if (!s2) armed <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pcnt         <= '0;
      scnt         <= '0;
      slen         <= '0;
      sidx         <= '0;
      hold         <= 1'b0;
      period       <= '0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
      cycle_marker <= 1'b0;
      slice_idx    <= '0;
    end else begin
      state        <= state_n;
      pcnt         <= pcnt_n;
      scnt         <= scnt_n;
      slen         <= slen_n;
      sidx         <= sidx_n;
      hold         <= hold_n;
      period       <= per_n;
      timeout      <= to_n;
      locked       <= (state_n == RUN);
      cycle_marker <= cm_n;
      slice_idx    <= sidx_n + off;
    end
  end

endmodule

// File: tb/tb_rotation_sync.sv
// tb_rotation_sync: directed vector bench for rotation_sync.
// SLICES=4 DEBOUNCE=2 MIN_PERIOD=16 DUTY_SHIFT=1 CNT_W=10.
module tb_rotation_sync;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hall_in = 1'b0;
  logic       cycle_marker;
  logic [1:0] slice_idx;
  logic       locked;
  logic [9:0] period;
  logic       timeout;
`ifdef SLICE_OFFSET_EN
  logic [1:0] phase_offset = 2'd3;
  int         off = 3;
`else
  int         off = 0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rotation_sync #(
    .SLICES(4), .CNT_W(10), .DEBOUNCE(2),
    .MIN_PERIOD(16), .DUTY_SHIFT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hall_in(hall_in),
`ifdef SLICE_OFFSET_EN
    .phase_offset(phase_offset),
`endif
    .cycle_marker(cycle_marker),
    .slice_idx(slice_idx),
    .locked(locked),
    .period(period),
    .timeout(timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulses are 4 clocks wide; 1950/1952 is a bounce glitch.
  function automatic bit hall_at(int c);
    int p[9] = '{1100, 1500, 1900, 2300, 2780,
                 3260, 4400, 4410, 4800};
    bit h = 1'b0;
    for (int i = 0; i < 9; i++)
      if (c >= p[i] && c <= p[i] + 3) h = 1'b1;
    if (c == 1950 || c == 1952) h = 1'b1;
    return h;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      hall_in = hall_at(cyc);
    end
  end

  task automatic chk(input string nm, input int c,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d want %0d",
               nm, c, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int sidx;
    int cm;
    int lk;
    int per;
    int to;
  } vec_t;

  vec_t tv[$];

  initial begin
    // Event effect edge = pulse start + 4.
    tv.push_back('{3,    0, 0, 0, 0,   0});
    tv.push_back('{1000, 0, 0, 0, 0,   0});
    tv.push_back('{1300, 0, 0, 0, 0,   0});
    tv.push_back('{1504, 0, 1, 1, 400, 0});
    tv.push_back('{1553, 0, 1, 1, 400, 0});
    tv.push_back('{1554, 0, 0, 1, 400, 0});
    tv.push_back('{1603, 0, 0, 1, 400, 0});
    tv.push_back('{1604, 1, 1, 1, 400, 0});
    tv.push_back('{1754, 2, 0, 1, 400, 0});
    tv.push_back('{1803, 2, 0, 1, 400, 0});
    tv.push_back('{1804, 3, 1, 1, 400, 0});
    tv.push_back('{1903, 3, 0, 1, 400, 0});
    tv.push_back('{1904, 0, 1, 1, 400, 0});
    tv.push_back('{1960, 0, 0, 1, 400, 0});
    tv.push_back('{2004, 1, 1, 1, 400, 0});
    tv.push_back('{2304, 0, 1, 1, 400, 0});
    tv.push_back('{2703, 3, 0, 1, 400, 0});
    tv.push_back('{2704, 3, 0, 1, 400, 0});
    tv.push_back('{2783, 3, 0, 1, 400, 0});
    tv.push_back('{2784, 0, 1, 1, 480, 0});
    tv.push_back('{2843, 0, 1, 1, 480, 0});
    tv.push_back('{2844, 0, 0, 1, 480, 0});
    tv.push_back('{2904, 1, 1, 1, 480, 0});
    tv.push_back('{3264, 0, 1, 1, 480, 0});
    tv.push_back('{3744, 3, 0, 1, 480, 0});
    tv.push_back('{4287, 3, 0, 1, 480, 0});
    tv.push_back('{4288, 0, 0, 0, 480, 1});
    tv.push_back('{4289, 0, 0, 0, 480, 0});
    tv.push_back('{4420, 0, 0, 0, 480, 0});
    tv.push_back('{4804, 0, 1, 1, 400, 0});
    tv.push_back('{4850, 0, 1, 1, 400, 0});

    #20 reset = 1'b0;

    foreach (tv[i]) begin
      vec_t v;
      string nm;
      v = tv[i];
      while (cyc < v.cyc) @(negedge clock);
      if (cyc != v.cyc) begin
        chk("schedule", cyc, cyc, v.cyc);
      end else begin
        $sformat(nm, "v%0d", i);
        chk({nm, ".slice_idx"}, cyc, int'(slice_idx),
            (v.sidx + off) % 4);
        chk({nm, ".cycle_marker"}, cyc, int'(cycle_marker), v.cm);
        chk({nm, ".locked"}, cyc, int'(locked), v.lk);
        chk({nm, ".period"}, cyc, int'(period), v.per);
        chk({nm, ".timeout"}, cyc, int'(timeout), v.to);
      end
    end

    // Asynchronous reset mid-RUN, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("arst.cycle_marker", cyc, int'(cycle_marker), 0);
    chk("arst.slice_idx", cyc, int'(slice_idx), 0);
    chk("arst.locked", cyc, int'(locked), 0);
    chk("arst.period", cyc, int'(period), 0);
    chk("arst.timeout", cyc, int'(timeout), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_rst.locked", cyc, int'(locked), 0);
    chk("post_rst.period", cyc, int'(period), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
